// File: rtl/tpu_mmul_seq.sv
// tpu_mmul_seq: sequencer for one TPU matrix-multiply pass.
// A start pulse clears the systolic accumulator rows. The block then
// enables the A/B FIFOs and the array for the skewed fill/drain window
// and pulses done.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      pass request, sampled only in IDLE
//   abort      cancel, honoured in CLEAR and COMPUTE
//   host_crow  host C-row select, passed to sa_crow while IDLE
//   busy       high in CLEAR and COMPUTE
//   done       single-cycle completion pulse
//   en         shared memA/memB/systolic_array enable (COMPUTE only)
//   sa_wren    systolic_array WrEn (CLEAR only; Cin is tied to zero)
//   sa_crow    systolic_array Crow
module tpu_mmul_seq #(
    parameter int DIM  = 8,
    parameter int CNTW = $clog2(3*DIM),
    parameter int ROWW = $clog2(DIM)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [ROWW-1:0] host_crow,
    output logic            busy,
    output logic            done,
    output logic            en,
    output logic            sa_wren,
    output logic [ROWW-1:0] sa_crow
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Last count value of each timed phase: DIM clear cycles,
    // then 3*DIM-2 compute cycles covering the skewed fill and drain.
    localparam logic [CNTW-1:0] CLR_LAST = CNTW'(DIM - 1);
    localparam logic [CNTW-1:0] CMP_LAST = CNTW'(3*DIM - 3);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // start beats abort here; abort is meaningless in IDLE
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CLR_LAST) begin
                    state_d = S_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_COMPUTE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CMP_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                // start is dropped here, never queued
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decodes; only the IDLE row mux looks at an input.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        en      = 1'b0;
        sa_wren = 1'b0;
        sa_crow = '0;
        unique case (state_q)
            S_IDLE: begin
                sa_crow = host_crow;
            end
            S_CLEAR: begin
                busy    = 1'b1;
                sa_wren = 1'b1;
                sa_crow = cnt_q[ROWW-1:0];
            end
            S_COMPUTE: begin
                busy = 1'b1;
                en   = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                sa_crow = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tpu_mmul_seq.sv
// tb_tpu_mmul_seq: checks DIM=2/4/8 sequencers side by side against
// a model based on elapsed cycles since the accepted start.
module tb_tpu_mmul_seq;

    localparam int DS [3] = '{2, 4, 8};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] host;

    logic       b2, d2, e2, w2;
    logic [0:0] c2;
    logic       b4, d4, e4, w4;
    logic [1:0] c4;
    logic       b8, d8, e8, w8;
    logic [2:0] c8;

    logic [3:0] fl [3];
    logic [2:0] cr [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int p        [3];
    int done_at  [3];
    int done_cnt [3];
    int en_cnt   [3];
    int wr_cnt   [3];
    int rise8 [$];
    logic prev8;
    int t0;

    always #5 clk = ~clk;

    tpu_mmul_seq #(.DIM(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .host_crow(host[0:0]), .busy(b2), .done(d2), .en(e2),
        .sa_wren(w2), .sa_crow(c2)
    );
    tpu_mmul_seq #(.DIM(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .host_crow(host[1:0]), .busy(b4), .done(d4), .en(e4),
        .sa_wren(w4), .sa_crow(c4)
    );
    tpu_mmul_seq #(.DIM(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .host_crow(host), .busy(b8), .done(d8), .en(e8),
        .sa_wren(w8), .sa_crow(c8)
    );

    assign fl[0] = {b2, d2, e2, w2};
    assign fl[1] = {b4, d4, e4, w4};
    assign fl[2] = {b8, d8, e8, w8};
    assign cr[0] = {2'b00, c2};
    assign cr[1] = {1'b0, c4};
    assign cr[2] = c8;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // p = cycles elapsed since the accepted start (0 = idle).
    function automatic int next_p(int d, int pv, logic s, logic a);
        if (pv == 0)
            return s ? 1 : 0;
        if (pv <= 4*d - 2)
            return a ? 0 : pv + 1;
        return 0;
    endfunction

    function automatic logic [3:0] exp_fl(int d, int pv);
        logic bz, dn, en_e, wr;
        bz   = (pv >= 1) && (pv <= 4*d - 2);
        dn   = (pv == 4*d - 1);
        en_e = (pv >= d + 1) && (pv <= 4*d - 2);
        wr   = (pv >= 1) && (pv <= d);
        return {bz, dn, en_e, wr};
    endfunction

    function automatic logic [2:0] exp_cr(int d, int pv, logic [2:0] h);
        if (pv == 0)
            return h & 3'(d - 1);
        if (pv <= d)
            return 3'(pv - 1);
        return 3'd0;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flags_d%0d_c%0d", DS[i], cyc),
                  32'(fl[i]), 32'(exp_fl(DS[i], p[i])));
            check($sformatf("crow_d%0d_c%0d", DS[i], cyc),
                  32'(cr[i]), 32'(exp_cr(DS[i], p[i], host)));
            if (fl[i][2]) begin
                done_at[i] = cyc;
                done_cnt[i]++;
            end
            en_cnt[i] += int'(fl[i][1]);
            wr_cnt[i] += int'(fl[i][0]);
        end
        if (fl[2][0] && !prev8)
            rise8.push_back(cyc);
        prev8 = fl[2][0];
    endtask

    task automatic step(input logic s, input logic a, input logic [2:0] h);
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            p[i] = rst_n ? next_p(DS[i], p[i], start, abort) : 0;
        cyc++;
        #1;
        start = s;
        abort = a;
        host  = h;
        #1;
        compare_all();
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 3; i++) begin
            done_at[i]  = -1000;
            done_cnt[i] = 0;
            en_cnt[i]   = 0;
            wr_cnt[i]   = 0;
        end
        rise8.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        host  = 3'd5;
        prev8 = 1'b0;
        for (int i = 0; i < 3; i++) p[i] = 0;
        clr_stats();
        repeat (2) @(posedge clk);
        #2;
        compare_all();
        #3;
        rst_n = 1'b1;

        // single pass: phase lengths and done timing
        clr_stats();
        step(1'b1, 1'b0, 3'd0);
        t0 = cyc;
        repeat (40) step(1'b0, 1'b0, 3'd0);
        check("pass_done_d2", 32'(done_at[0] - t0), 32'd7);
        check("pass_done_d4", 32'(done_at[1] - t0), 32'd15);
        check("pass_done_d8", 32'(done_at[2] - t0), 32'd31);
        check("pass_en_d2", 32'(en_cnt[0]), 32'd4);
        check("pass_en_d4", 32'(en_cnt[1]), 32'd10);
        check("pass_en_d8", 32'(en_cnt[2]), 32'd22);
        check("pass_clr_d2", 32'(wr_cnt[0]), 32'd2);
        check("pass_clr_d4", 32'(wr_cnt[1]), 32'd4);
        check("pass_clr_d8", 32'(wr_cnt[2]), 32'd8);

        // start held high: second clear starts at t0+33
        clr_stats();
        step(1'b1, 1'b0, 3'd0);
        t0 = cyc;
        repeat (36) step(1'b1, 1'b0, 3'd0);
        repeat (40) step(1'b0, 1'b0, 3'd0);
        check("b2b_rises", 32'(rise8.size()), 32'd2);
        if (rise8.size() >= 2) begin
            check("b2b_first", 32'(rise8[0] - t0), 32'd1);
            check("b2b_second", 32'(rise8[1] - t0), 32'd33);
        end

        // abort in COMPUTE, then a fresh pass
        clr_stats();
        step(1'b1, 1'b0, 3'd0);
        t0 = cyc;
        repeat (14) step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        check("abort_idle_d8", 32'(fl[2]), 32'd0);
        repeat (3) step(1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0);
        repeat (40) step(1'b0, 1'b0, 3'd0);
        check("abort_done_cnt", 32'(done_cnt[2]), 32'd1);
        check("abort_done_at", 32'(done_at[2] - t0), 32'd51);

        // async reset in the middle of CLEAR
        step(1'b1, 1'b0, 3'd3);
        repeat (4) step(1'b0, 1'b0, 3'd3);
        check("pre_rst_clear", 32'(fl[2]), 32'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) p[i] = 0;
        compare_all();
        check("rst_async_d8", 32'(fl[2]), 32'd0);
        #2;
        rst_n = 1'b1;
        clr_stats();
        repeat (10) step(1'b0, 1'b0, 3'd6);
        check("rst_stays_idle", 32'(wr_cnt[2] + en_cnt[2]), 32'd0);

        // host readback sweep, then host changes during a pass
        for (int h = 0; h < 8; h++) step(1'b0, 1'b0, 3'(h));
        step(1'b1, 1'b0, 3'd2);
        repeat (30) step(1'b0, 1'b0, 3'($urandom_range(0, 7)));

        // random traffic
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 3'($urandom_range(0, 7)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_mmul_seq.md
# tpu_mmul_seq

Sequencer for one matrix-multiply pass of the TPU datapath. It takes a single start pulse and clears the DIM accumulator rows of the systolic array. It then drives the shared enable of the A FIFO, B FIFO and systolic array for exactly the number of cycles needed to stream a DIM×DIM product, and signals completion. It sits between the memory-mapped host decode (start strobe, C-row readback) and the memA/memB/systolic_array instances.

## Interface
- DIM, default 8: matrix dimension; must be ≥ 2.
- CNTW, default $clog2(3*DIM): width of the internal cycle counter.
- ROWW, default $clog2(DIM): width of the C row index.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request one multiply pass; sampled only in IDLE.
- abort  input  1  synchronous cancel; honoured in CLEAR and COMPUTE.
- host_crow  input  ROWW  C row selected by host readback while IDLE.
- busy  output  1  high in CLEAR and COMPUTE.
- done  output  1  one-cycle completion pulse (DONE state).
- en  output  1  shared enable to memA, memB and systolic_array; high only in COMPUTE.
- sa_wren  output  1  systolic_array WrEn; high only in CLEAR (Cin is tied to zero at integration).
- sa_crow  output  ROWW  systolic_array Crow.

## Operation
- States: IDLE, CLEAR, COMPUTE, DONE. The state and a CNTW-bit counter are the only storage.
- IDLE:
  - With start=1, go to CLEAR and set cnt=0.
  - Otherwise stay in IDLE.
  - sa_crow = host_crow (combinational pass-through), so the host can read C rows between passes.
- CLEAR:
  - sa_wren=1 and sa_crow=cnt[ROWW-1:0], which zeroes rows 0..DIM-1 in order.
  - cnt increments each cycle. When cnt==DIM-1, go to COMPUTE and set cnt=0.
- COMPUTE:
  - en=1 and sa_crow=0.
  - cnt increments each cycle. When cnt==3*DIM-3 (3*DIM-2 cycles total, the skewed fill/drain length), go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle, then go to IDLE unconditionally.
  - start is ignored in DONE.
- abort:
  - In CLEAR or COMPUTE, go to IDLE on the next edge. cnt clears and done is never pulsed.
  - In IDLE or DONE, abort has no effect.
  - If abort and start are both high in IDLE, start wins.
- start while busy or in DONE is dropped. It is not queued.
- Outputs are Moore decodes of state/cnt, apart from the sa_crow mux in IDLE.
- No arithmetic is performed beyond counter increments. The counter never wraps, because each state clears it before CNTW overflows.

## Timing
- Reset (asynchronous, any state, including mid-pass):
  - state=IDLE and cnt=0.
  - busy=0, done=0, en=0, sa_wren=0, sa_crow=host_crow.
- Let start be sampled high at edge t:
  - CLEAR occupies cycles t+1..t+DIM.
  - COMPUTE occupies t+DIM+1..t+4·DIM−2.
  - done is high during cycle t+4·DIM−1.
  - For DIM=8: 8 clear cycles, 22 en cycles, done in cycle t+31.
- The earliest next start is sampled at the edge ending the done cycle plus one, i.e. first IDLE cycle t+4·DIM.
- Abort sampled high at edge k: state is IDLE from cycle k+1. en and sa_wren are low in cycle k+1.
- en is never high in the same cycle as sa_wren. done is never high in the same cycle as busy.

## Test plan
- Reset then single pass, DIM=8:
  - start pulse at cycle 0 -> sa_wren high cycles 1–8 with sa_crow 0,1,…,7.
  - en high cycles 9–30 (22 cycles).
  - done high only in cycle 31; busy high cycles 1–30.
- Back-to-back: hold start high continuously -> second CLEAR begins cycle 33. No start is accepted during cycles 1–31.
- Abort in COMPUTE:
  - abort at cycle 15 -> en low and state IDLE from cycle 16, no done.
  - A fresh start at cycle 20 gives done at cycle 51.
- Async reset mid-CLEAR:
  - assert rst_n=0 at cycle 4 between edges -> busy, sa_wren and en drop immediately.
  - After release the block stays in IDLE until start.
- Host readback: in IDLE, sweep host_crow 0..7 -> sa_crow follows in the same cycle. During COMPUTE, a host_crow change leaves sa_crow at 0.
- Parameter sweep DIM=2 and DIM=4:
  - DIM=2: clear lasts 2 cycles and en lasts 4 cycles; done at t+7.
  - DIM=4: clear lasts 4 cycles and en lasts 10 cycles; done at t+15.
